// File: rtl/hasti_arbiter_pkg.sv
// Shared types, constants and helpers for the HASTI multi-master grant controller.
//   MAX_MASTERS   : largest supported requester count
//   arb_state_t   : arbiter FSM state encoding (ARB_IDLE / ARB_OWN / ARB_LOCK)
//   idx_w()       : index width for a given master count (minimum 1 bit)
//   onehot_to_idx : encode a one-hot grant vector into its bit index
package hasti_arbiter_pkg;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned MAX_IDXW    = 3;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_OWN  = 2'd1;
    localparam arb_state_t ARB_LOCK = 2'd2;

    // Width needed to hold an index into n masters; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // OR-reduction encoder; only meaningful for one-hot or all-zero inputs.
    function automatic logic [MAX_IDXW-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MAX_IDXW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | MAX_IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hasti_arbiter_if.sv
// Request/grant bundle between the master skid buffers, the arbiter and the slave mux.
//   req, lock, seq : per-master request, hmastlock and htrans==SEQ of the pending phase
//   hready         : slave hreadyout
//   gnt_addr       : one-hot address-phase grant (combinational)
//   gnt_data       : one-hot data-phase grant (registered)
//   gnt_any        : |gnt_addr, drives slave hsel
//   owner          : index of the last accepted address phase
// Modport master is the requester/bus side, modport slave is the arbiter.
interface hasti_arbiter_if #(
    parameter int unsigned NMASTERS = 2
) ();
    import hasti_arbiter_pkg::*;

    localparam int unsigned IDXW = idx_w(NMASTERS);

    logic [NMASTERS-1:0] req;
    logic [NMASTERS-1:0] lock;
    logic [NMASTERS-1:0] seq;
    logic                hready;
    logic [NMASTERS-1:0] gnt_addr;
    logic [NMASTERS-1:0] gnt_data;
    logic                gnt_any;
    logic [IDXW-1:0]     owner;

    modport master (
        output req, lock, seq, hready,
        input  gnt_addr, gnt_data, gnt_any, owner
    );

    modport slave (
        input  req, lock, seq, hready,
        output gnt_addr, gnt_data, gnt_any, owner
    );

endinterface

// File: rtl/hasti_rr_pick.sv
// Rotate-priority picker: first set request bit searching upward from ptr_i+1, wrapping modulo N.
//   req_i    : request vector
//   ptr_i    : index of the most recent winner (search starts just above it)
//   onehot_o : one-hot winner, zero when no request
//   idx_o    : encoded winner index
//   any_o    : at least one request present
module hasti_rr_pick
    import hasti_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int unsigned cand;
    logic        found;

    // Walk N candidates starting after ptr_i; ptr_i < N so one subtraction wraps.
    always_comb begin
        onehot_o = '0;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N) cand = cand - N;
            if (!found && req_i[IW'(cand)]) begin
                found                  = 1'b1;
                onehot_o[IW'(cand)]    = 1'b1;
            end
        end
    end

    assign idx_o = IW'(onehot_to_idx(MAX_MASTERS'(onehot_o)));
    assign any_o = |req_i;

endmodule

// File: rtl/hasti_arbiter.sv
// Round-robin grant controller for a HASTI multi-master-to-one-slave mux with lock and burst hold.
//   hclk, hresetn : bus clock, asynchronous active-low reset
//   bus (slave)   : req/lock/seq/hready in; gnt_addr/gnt_any (combinational),
//                   gnt_data/owner (registered) out
// Build option HASTI_ARB_FIXED_PRIO_EN: pins the rotate pointer at NMASTERS-1 so the
// lowest requesting index always wins; lock and burst hold behave the same either way.
module hasti_arbiter
    import hasti_arbiter_pkg::*;
#(
    parameter int unsigned NMASTERS = 2
) (
    input  logic           hclk,
    input  logic           hresetn,
    hasti_arbiter_if.slave bus
);

    localparam int unsigned         IDXW      = idx_w(NMASTERS);
    localparam logic [IDXW-1:0]     PTR_RESET = IDXW'(NMASTERS - 1);
    localparam logic [NMASTERS-1:0] ONE       = NMASTERS'(1);

    arb_state_t          state_q, state_d;
    logic [IDXW-1:0]     owner_q, owner_d;
    logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NMASTERS-1:0] gnt_data_q, gnt_data_d;

    logic [NMASTERS-1:0] pick_oh;
    logic [IDXW-1:0]     pick_idx;
    logic                pick_any;

    logic [NMASTERS-1:0] owner_oh;
    logic [NMASTERS-1:0] gnt_addr_c;
    logic [IDXW-1:0]     acc_idx;
    logic                acc_lock;
    logic                gnt_any_c;
    logic                freeze;
    logic                hold;

    hasti_rr_pick #(
        .N  (NMASTERS),
        .IW (IDXW)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Grant selection: wait-state freeze, then lock/burst hold, then rotate pick.
    always_comb begin
        owner_oh = ONE << owner_q;
        // A nonzero data-phase grant means the last accepted phase was a real transfer.
        freeze   = !bus.hready && (|gnt_data_q);
        // A lock or burst only holds while the owner is still requesting.
        hold     = bus.req[owner_q] &&
                   (((state_q == ARB_LOCK) && bus.lock[owner_q]) || bus.seq[owner_q]);
        if (freeze || hold) begin
            gnt_addr_c = owner_oh;
            gnt_any_c  = 1'b1;
            acc_idx    = owner_q;
        end else begin
            gnt_addr_c = pick_oh;
            gnt_any_c  = pick_any;
            acc_idx    = pick_idx;
        end
        acc_lock = bus.lock[acc_idx];
    end

    // Next-state: every update is qualified by hready.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_data_d = gnt_data_q;
        if (bus.hready) begin
            gnt_data_d = gnt_addr_c;
            if (gnt_any_c) begin
                owner_d = acc_idx;
`ifdef HASTI_ARB_FIXED_PRIO_EN
                rr_ptr_d = PTR_RESET;
`else
                rr_ptr_d = acc_idx;
`endif
            end
            case (state_q)
                ARB_IDLE: begin
                    if (gnt_any_c) state_d = acc_lock ? ARB_LOCK : ARB_OWN;
                end
                ARB_OWN, ARB_LOCK: begin
                    if (!gnt_any_c) state_d = ARB_IDLE;
                    else            state_d = acc_lock ? ARB_LOCK : ARB_OWN;
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // State and grant registers; reset points the rotor at the top so port 0 wins first.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= PTR_RESET;
            gnt_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_data_q <= gnt_data_d;
        end
    end

    assign bus.gnt_addr = gnt_addr_c;
    assign bus.gnt_any  = gnt_any_c;
    assign bus.gnt_data = gnt_data_q;
    assign bus.owner    = owner_q;

`ifndef SYNTHESIS
    a_gnt_addr_onehot: assert property (@(posedge hclk) disable iff (!hresetn)
        $onehot0(gnt_addr_c));
    a_gnt_data_onehot: assert property (@(posedge hclk) disable iff (!hresetn)
        $onehot0(gnt_data_q));
    a_addr_stable_in_wait: assert property (@(posedge hclk) disable iff (!hresetn)
        freeze |=> (bus.hready || $stable(gnt_addr_c)));
`endif

endmodule

// File: tb/tb_hasti_arbiter.sv
// Self-checking bench for hasti_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the grant rules.
module tb_hasti_arbiter;

    localparam int N = 2;

    logic hclk;
    logic hresetn;
    int   total = 0;
    int   bad   = 0;

    // Reference model state: last accepted owner, rotor position, data-phase grant (-1 none).
    int m_owner;
    int m_ptr;
    int m_data;
    bit m_locked;

    hasti_arbiter_if #(.NMASTERS(N)) bus ();

    hasti_arbiter #(.NMASTERS(N)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v = N'(1) << i;
        return v;
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_ptr    = N - 1;
        m_data   = -1;
        m_locked = 1'b0;
    endtask

    // Which master should own the address phase right now (-1 for none).
    function automatic int model_grant();
        int c;
        if (!bus.hready && m_data >= 0) return m_owner;
        if (bus.req[m_owner] && ((m_locked && bus.lock[m_owner]) || bus.seq[m_owner]))
            return m_owner;
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (bus.req[c]) return c;
        end
        return -1;
    endfunction

    // One bus cycle: apply inputs, check all outputs against the model, clock, update model.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] s,
                        input logic h, output logic [N-1:0] g);
        int eg;
        bus.req    = r;
        bus.lock   = l;
        bus.seq    = s;
        bus.hready = h;
        #2;
        eg = model_grant();
        g  = bus.gnt_addr;
        check_eq("gnt_addr", 32'(bus.gnt_addr), 32'(oh(eg)));
        check_eq("gnt_any",  32'(bus.gnt_any),  32'(eg >= 0));
        check_eq("gnt_data", 32'(bus.gnt_data), 32'(oh(m_data)));
        check_eq("owner",    32'(bus.owner),    32'(m_owner));
        @(posedge hclk);
        if (h) begin
            m_data = eg;
            if (eg >= 0) begin
                m_owner  = eg;
`ifndef HASTI_ARB_FIXED_PRIO_EN
                m_ptr    = eg;
`endif
                m_locked = l[eg];
            end else begin
                m_locked = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [N-1:0] g;
        int           cnt0;
        int           cnt1;

        hresetn    = 1'b0;
        bus.req    = '0;
        bus.lock   = '0;
        bus.seq    = '0;
        bus.hready = 1'b1;
        model_reset();
        #12;
        check_eq("rst_gnt_data", 32'(bus.gnt_data), 32'd0);
        check_eq("rst_gnt_any",  32'(bus.gnt_any),  32'd0);
        check_eq("rst_owner",    32'(bus.owner),    32'd0);
        hresetn = 1'b1;

        // Both masters requesting: strict alternation starting at port 0.
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'b00, 2'b00, 1'b1, g);
            if (g == 2'b01) cnt0++;
            if (g == 2'b10) cnt1++;
`ifdef HASTI_ARB_FIXED_PRIO_EN
            check_eq("fixed_prio", 32'(g), 32'd1);
`else
            check_eq("fair_seq", 32'(g), (i % 2 == 0) ? 32'd1 : 32'd2);
`endif
        end
`ifndef HASTI_ARB_FIXED_PRIO_EN
        check_eq("fair_cnt0", 32'(cnt0), 32'd3);
        check_eq("fair_cnt1", 32'(cnt1), 32'd3);
`endif

        // Locked master 1 holds the bus against master 0 until it drops lock.
        step(2'b10, 2'b10, 2'b00, 1'b1, g);
        check_eq("lock_win", 32'(g), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b10, 2'b00, 1'b1, g);
            check_eq("lock_hold", 32'(g), 32'd2);
        end
        step(2'b11, 2'b00, 2'b00, 1'b1, g);
        check_eq("lock_rel", 32'(g), 32'd1);

        // Master 0 burst: SEQ beats keep the grant despite master 1 requesting.
        step(2'b01, 2'b00, 2'b00, 1'b1, g);
        check_eq("burst_first", 32'(g), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 2'b00, 2'b01, 1'b1, g);
            check_eq("burst_hold", 32'(g), 32'd1);
        end
        step(2'b11, 2'b00, 2'b00, 1'b1, g);
`ifdef HASTI_ARB_FIXED_PRIO_EN
        check_eq("burst_end", 32'(g), 32'd1);
`else
        check_eq("burst_end", 32'(g), 32'd2);
`endif

        // Wait states: grants frozen while requests move from master 0 to master 1.
        step(2'b01, 2'b00, 2'b00, 1'b1, g);
        check_eq("wait_pre", 32'(g), 32'd1);
        step(2'b01, 2'b00, 2'b00, 1'b0, g);
        check_eq("wait_addr", 32'(g), 32'd1);
        check_eq("wait_data", 32'(bus.gnt_data), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(2'b10, 2'b00, 2'b00, 1'b0, g);
            check_eq("wait_addr", 32'(g), 32'd1);
            check_eq("wait_data", 32'(bus.gnt_data), 32'd1);
        end
        step(2'b10, 2'b00, 2'b00, 1'b1, g);
        check_eq("wait_post", 32'(g), 32'd2);
        check_eq("wait_data_post", 32'(bus.gnt_data), 32'd2);

        // Asynchronous reset in the middle of a stalled transfer.
        step(2'b11, 2'b00, 2'b00, 1'b1, g);
        bus.hready = 1'b0;
        bus.req    = '0;
        #2;
        hresetn = 1'b0;
        #1;
        check_eq("midrst_gnt_data", 32'(bus.gnt_data), 32'd0);
        check_eq("midrst_owner",    32'(bus.owner),    32'd0);
        check_eq("midrst_gnt_any",  32'(bus.gnt_any),  32'd0);
        model_reset();
        @(posedge hclk);
        #1;
        hresetn    = 1'b1;
        bus.hready = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] r;
            logic [N-1:0] l;
            logic [N-1:0] s;
            logic         h;
            r = N'($urandom);
            l = N'($urandom) & N'($urandom);
            s = N'($urandom) & N'($urandom);
            h = ($urandom_range(0, 3) != 0);
            step(r, l, s, h, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
